spi_slv_frame: RTL and testbench
================================

Name: spi_slv_frame

Overview:
- Frame engine of the SPI slave, clocked by `spi_clk`, which is produced by the SPI clock-select stage directly upstream. That stage has already resolved CPOL/CPHA, so the sampling edge is always the rising edge of `spi_clk`.
- Deserialises MOSI words and decodes a command word (R/W plus address).
- Emits write transactions and read requests with auto-incrementing address, and serialises read data on MISO.
- Transactions cross into the register domain through toggle handshakes.

Parameters:
- `DATA_W`, default 8: bits per SPI word. Minimum 4.
- `ADDR_W`, default `DATA_W-1`: address width carried in the command word. Fixed as `DATA_W-1`; not user-overridable.

Ports:
- `spi_clk` input 1: rising edge samples MOSI and updates all state.
- `rst_n` input 1: asynchronous, active-low reset. Integration drives `rst_n = sys_rst_n & ~spi_cs`, so chip-select deassertion aborts the frame.
- `spi_mosi` input 1: serial data in, MSB first.
- `spi_miso` output 1: serial data out, MSB first.
- `spi_miso_oe` output 1: MISO output enable.
- `wr_addr` output `ADDR_W`: write address, held stable between toggles.
- `wr_data` output `DATA_W`: write data, held stable between toggles.
- `wr_tgl` output 1: toggles once per completed write word.
- `rd_addr` output `ADDR_W`: read request address, held stable between toggles.
- `rd_tgl` output 1: toggles once per read request.
- `rd_data` input `DATA_W`: read data from the register domain. Must be stable no later than one full word time after the `rd_tgl` toggle.

Behaviour:
- Reset values (`rst_n` low):
  - state = `CMD`, bit counter = 0, shift registers = 0, address counter = 0.
  - `wr_addr`, `wr_data`, `rd_addr` = 0.
  - `wr_tgl`, `rd_tgl` = 0.
  - `spi_miso` = 0, `spi_miso_oe` = 0.
- `spi_miso_oe` is registered. It goes to 1 on the first rising `spi_clk` after reset release and stays 1 until reset.
- Bit counter:
  - Counts 0..`DATA_W-1` on each rising edge, then wraps to 0.
  - Completed word = `{shift_in[DATA_W-2:0], spi_mosi}` sampled at count `DATA_W-1`.
  - A word completion is processed on that same edge.
- State `CMD`, on word completion:
  - addr_cnt <= word[`ADDR_W-1`:0].
  - If word[`DATA_W-1`]=0: go to `WR`.
  - If word[`DATA_W-1`]=1: set `rd_addr` <= word[`ADDR_W-1`:0], toggle `rd_tgl`, go to `RD_DUMMY`.
- State `WR`, on each word completion:
  - `wr_addr` <= addr_cnt, `wr_data` <= word, toggle `wr_tgl`.
  - addr_cnt++ modulo 2^`ADDR_W`.
  - Stay in `WR`.
- State `RD_DUMMY`:
  - MISO = 0 for the whole word; the incoming MOSI word is ignored.
  - On completion: tx_shift <= `rd_data`, addr_cnt++, `rd_addr` <= addr_cnt+1, toggle `rd_tgl`, go to `RD`.
- State `RD`:
  - MISO = tx_shift MSB; tx_shift shifts left on each edge.
  - On completion: tx_shift <= `rd_data` (the value for the prefetched `rd_addr`), addr_cnt++, `rd_addr` <= addr_cnt+1, toggle `rd_tgl`.
  - The final prefetch of a frame is discarded by design; register reads must be side-effect free.
- MISO timing:
  - `spi_miso` is registered and updated on the rising edge.
  - The first data bit is visible after the edge that completes the previous word, giving the master one full `spi_clk` period of setup.
  - MISO = 0 in `CMD` and `WR`.
- Read latency: the register domain has exactly one word time (`DATA_W` `spi_clk` periods) from a `rd_tgl` toggle until `rd_data` is sampled.
- Reset mid-word: the partial word is discarded with no toggle. The toggle outputs return to 0; the register domain resynchronises its edge detectors on the same reset.
- Address wrap: `0x7F` + 1 = `0x00` for `DATA_W`=8. There is no error flag.
- A frame consisting only of a command word:
  - Write command: no `wr_tgl` toggle.
  - Read command: exactly one `rd_tgl` toggle.
- No `spi_clk` edges arrive while `spi_cs` is inactive, because the upstream stage gates the clock. The block therefore needs no idle state.

Decomposition:
- Package `spi_slv_pkg`:
  - State enum `{CMD, WR, RD_DUMMY, RD}`.
  - `SPI_DATA_W_DEF` = 8.
  - `CMD_RD_BIT` = `DATA_W-1`.
- Sub-module `spi_slv_shreg`:
  - Contains the bit counter, shift-in register, tx shift register with parallel load, and the `word_done` strobe.
  - The FSM, address counter and handshakes stay in the top module.

Test Plan (`DATA_W`=8; register model returns `rd_data` = `~rd_addr` in the low bits):
1. Write: frame bytes `0x05`, `0xA5`, `0x3C` -> `wr_tgl` toggles twice with (`wr_addr`, `wr_data`) = (`0x05`, `0xA5`) then (`0x06`, `0x3C`); `rd_tgl` never toggles.
2. Read: frame `0x90`, dummy, 2 words -> MISO bytes `0x00`, `0x00`, `0xEF`, `0xEE`; `rd_addr` sequence `0x10`, `0x11`, `0x12`, `0x13` with 4 `rd_tgl` toggles.
3. Wrap: write command `0x7F` with data `0x11`, `0x22` -> writes to `0x7F` then `0x00`.
4. Abort: write command `0x20`, then `rst_n` low after 5 data bits -> no `wr_tgl`. The next frame `0x21`, `0x55` writes `0x55` to `0x21`, proving the bit counter and FSM were reset.
5. Reset check: assert `rst_n` mid-read -> all outputs and toggles return to 0 asynchronously, without any `spi_clk` edge.
6. Command-only frames: a lone `0x40` frame gives no toggles; a lone `0xC0` frame gives exactly one `rd_tgl` toggle with `rd_addr` = `0x40`.

Source files
------------

// File: rtl/spi_slv_pkg.sv
// Shared types and constants for the SPI slave frame engine.
package spi_slv_pkg;

  // Frame phases: command word, write data, read dummy word, read data.
  typedef enum logic [1:0] {
    CMD      = 2'd0,
    WR       = 2'd1,
    RD_DUMMY = 2'd2,
    RD       = 2'd3
  } spi_state_e;

  localparam int SPI_DATA_W_DEF = 8;

  // The read/write flag sits in the MSB of the command word.
  localparam int CMD_RD_BIT = SPI_DATA_W_DEF - 1;

  // Same position for a non-default word width.
  function automatic int cmd_rd_bit(input int dataW);
    return dataW - 1;
  endfunction

endpackage

// File: rtl/spi_slv_shreg.sv
// Bit counter, receive shifter and transmit shifter of the SPI slave.
module spi_slv_shreg
  import spi_slv_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              mosi_i,
  input  logic              txLoad_i,
  input  logic [DATA_W-1:0] txData_i,
  output logic              wordDone_o,
  output logic [DATA_W-1:0] word_o,
  output logic              txMsbNext_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  logic [CNT_W-1:0]  bitCnt_q;
  logic [DATA_W-1:0] shIn_q;
  logic [DATA_W-1:0] tx_q;

  // The word is complete on the edge that samples its last bit, so the
  // current MOSI level is appended to the already shifted-in bits.
  assign wordDone_o  = (bitCnt_q == CNT_LAST);
  assign word_o      = {shIn_q[DATA_W-2:0], mosi_i};
  assign txMsbNext_o = txLoad_i ? txData_i[DATA_W-1] : tx_q[DATA_W-2];

  // Bit position within the word, wrapping after the last bit.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      bitCnt_q <= '0;
    end else if (wordDone_o) begin
      bitCnt_q <= '0;
    end else begin
      bitCnt_q <= bitCnt_q + 1'b1;
    end
  end

  // MSB-first deserialiser for MOSI.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      shIn_q <= '0;
    end else begin
      shIn_q <= {shIn_q[DATA_W-2:0], mosi_i};
    end
  end

  // Transmit shifter: parallel load at word end, otherwise shift left.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      tx_q <= '0;
    end else if (txLoad_i) begin
      tx_q <= txData_i;
    end else begin
      tx_q <= {tx_q[DATA_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/spi_slv_frame.sv
// SPI slave frame engine: command decode, auto-increment addressing,
// toggle handshakes towards the register domain and MISO serialisation.
module spi_slv_frame
  import spi_slv_pkg::*;
#(
  parameter int DATA_W = SPI_DATA_W_DEF
) (
  input  logic              spi_clk,
  input  logic              rst_n,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [DATA_W-2:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_tgl,
  output logic [DATA_W-2:0] rd_addr,
  output logic              rd_tgl,
  input  logic [DATA_W-1:0] rd_data
);

  // Address width is tied to the command word layout.
  localparam int ADDR_W = DATA_W - 1;
  localparam int RD_BIT = cmd_rd_bit(DATA_W);

  spi_state_e        state_q;
  logic [ADDR_W-1:0] addrCnt_q;
  logic [ADDR_W-1:0] wrAddr_q;
  logic [DATA_W-1:0] wrData_q;
  logic              wrTgl_q;
  logic [ADDR_W-1:0] rdAddr_q;
  logic              rdTgl_q;
  logic              miso_q;
  logic              misoOe_q;

  logic              wordDone;
  logic [DATA_W-1:0] word;
  logic              txMsbNext;
  logic              txLoad;
  logic              inReadData_d;
  logic [ADDR_W-1:0] addrNext;

  assign addrNext = addrCnt_q + 1'b1;

  // Read data is loaded at the end of the dummy word and of every read word.
  assign txLoad = wordDone && ((state_q == RD_DUMMY) || (state_q == RD));

  // MISO carries data only while the state after this edge is RD.
  assign inReadData_d = (state_q == RD) || ((state_q == RD_DUMMY) && wordDone);

  spi_slv_shreg #(
    .DATA_W (DATA_W)
  ) u_shreg (
    .clk_i       (spi_clk),
    .rst_n_i     (rst_n),
    .mosi_i      (spi_mosi),
    .txLoad_i    (txLoad),
    .txData_i    (rd_data),
    .wordDone_o  (wordDone),
    .word_o      (word),
    .txMsbNext_o (txMsbNext)
  );

  // Frame FSM with address counter and write/read toggle handshakes.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CMD;
      addrCnt_q <= '0;
      wrAddr_q  <= '0;
      wrData_q  <= '0;
      wrTgl_q   <= 1'b0;
      rdAddr_q  <= '0;
      rdTgl_q   <= 1'b0;
    end else if (wordDone) begin
      case (state_q)
        CMD: begin
          addrCnt_q <= word[ADDR_W-1:0];
          if (word[RD_BIT]) begin
            rdAddr_q <= word[ADDR_W-1:0];
            rdTgl_q  <= ~rdTgl_q;
            state_q  <= RD_DUMMY;
          end else begin
            state_q  <= WR;
          end
        end
        WR: begin
          wrAddr_q  <= addrCnt_q;
          wrData_q  <= word;
          wrTgl_q   <= ~wrTgl_q;
          addrCnt_q <= addrNext;
        end
        RD_DUMMY, RD: begin
          addrCnt_q <= addrNext;
          rdAddr_q  <= addrNext;
          rdTgl_q   <= ~rdTgl_q;
          state_q   <= RD;
        end
        default: state_q <= CMD;
      endcase
    end
  end

  // Registered MISO and its enable, driven high from the first edge on.
  always_ff @(posedge spi_clk or negedge rst_n) begin
    if (!rst_n) begin
      miso_q   <= 1'b0;
      misoOe_q <= 1'b0;
    end else begin
      miso_q   <= inReadData_d ? txMsbNext : 1'b0;
      misoOe_q <= 1'b1;
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = misoOe_q;
  assign wr_addr     = wrAddr_q;
  assign wr_data     = wrData_q;
  assign wr_tgl      = wrTgl_q;
  assign rd_addr     = rdAddr_q;
  assign rd_tgl      = rdTgl_q;

endmodule

// File: tb/tb_spi_slv_frame.sv
// Directed bench for the SPI slave frame engine with an 8-bit word.
module tb_spi_slv_frame;

  logic       spiClk;
  logic       rstN;
  logic       spiMosi;
  logic       spiMiso;
  logic       spiMisoOe;
  logic [6:0] wrAddr;
  logic [7:0] wrData;
  logic       wrTgl;
  logic [6:0] rdAddr;
  logic       rdTgl;
  logic [7:0] rdData;

  int compared;
  int mismatched;

  logic [14:0] wrLog[$];
  logic [6:0]  rdLog[$];
  logic        prevWr;
  logic        prevRd;

  spi_slv_frame #(
    .DATA_W (8)
  ) dut (
    .spi_clk     (spiClk),
    .rst_n       (rstN),
    .spi_mosi    (spiMosi),
    .spi_miso    (spiMiso),
    .spi_miso_oe (spiMisoOe),
    .wr_addr     (wrAddr),
    .wr_data     (wrData),
    .wr_tgl      (wrTgl),
    .rd_addr     (rdAddr),
    .rd_tgl      (rdTgl),
    .rd_data     (rdData)
  );

  // Register model: every address reads back as its inverse.
  assign rdData = ~{1'b0, rdAddr};

  initial spiClk = 1'b0;
  always #5 spiClk = ~spiClk;

  task automatic sample_toggles();
    if (wrTgl !== prevWr) begin
      wrLog.push_back({wrAddr, wrData});
      prevWr = wrTgl;
    end
    if (rdTgl !== prevRd) begin
      rdLog.push_back(rdAddr);
      prevRd = rdTgl;
    end
  endtask

  task automatic start_frame();
    @(negedge spiClk);
    wrLog.delete();
    rdLog.delete();
    prevWr = 1'b0;
    prevRd = 1'b0;
    rstN = 1'b1;
  endtask

  task automatic send_bits(input logic [7:0] tx, input int nBits, output logic [7:0] rx);
    rx = 8'h00;
    for (int i = 7; i > 7 - nBits; i--) begin
      rx[i] = spiMiso;
      spiMosi = tx[i];
      @(negedge spiClk);
      sample_toggles();
    end
  endtask

  task automatic end_frame();
    rstN = 1'b0;
    #1;
    prevWr = 1'b0;
    prevRd = 1'b0;
  endtask

  task automatic test_reset();
    rstN = 1'b0;
    spiMosi = 1'b0;
    repeat (2) @(negedge spiClk);
    compared++;
    if ({spiMiso, spiMisoOe, wrAddr, wrData, wrTgl, rdAddr, rdTgl} !== 25'h0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got %h want 0",
               {spiMiso, spiMisoOe, wrAddr, wrData, wrTgl, rdAddr, rdTgl});
    end
  endtask

  task automatic test_write();
    logic [7:0] rx;
    start_frame();
    send_bits(8'h05, 8, rx);
    compared++;
    if (spiMisoOe !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL write_oe: got %b want 1", spiMisoOe);
    end
    send_bits(8'hA5, 8, rx);
    send_bits(8'h3C, 8, rx);
    compared++;
    if (wrLog.size() !== 2) begin
      mismatched++;
      $display("[TB] FAIL write_count: got %0d want 2", wrLog.size());
    end else begin
      compared++;
      if (wrLog[0] !== {7'h05, 8'hA5}) begin
        mismatched++;
        $display("[TB] FAIL write_first: got %h want %h", wrLog[0], {7'h05, 8'hA5});
      end
      compared++;
      if (wrLog[1] !== {7'h06, 8'h3C}) begin
        mismatched++;
        $display("[TB] FAIL write_second: got %h want %h", wrLog[1], {7'h06, 8'h3C});
      end
    end
    compared++;
    if (rdLog.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL write_no_read: got %0d want 0", rdLog.size());
    end
    end_frame();
  endtask

  task automatic test_read();
    logic [7:0] rx;
    logic [7:0] txWords[4];
    logic [7:0] expRx[4];
    logic [6:0] expAddr[4];
    txWords = '{8'h90, 8'hFF, 8'h5A, 8'hC3};
    expRx   = '{8'h00, 8'h00, 8'hEF, 8'hEE};
    expAddr = '{7'h10, 7'h11, 7'h12, 7'h13};
    start_frame();
    for (int w = 0; w < 4; w++) begin
      send_bits(txWords[w], 8, rx);
      compared++;
      if (rx !== expRx[w]) begin
        mismatched++;
        $display("[TB] FAIL read_miso_%0d: got %h want %h", w, rx, expRx[w]);
      end
    end
    compared++;
    if (rdLog.size() !== 4) begin
      mismatched++;
      $display("[TB] FAIL read_count: got %0d want 4", rdLog.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        compared++;
        if (rdLog[k] !== expAddr[k]) begin
          mismatched++;
          $display("[TB] FAIL read_addr_%0d: got %h want %h", k, rdLog[k], expAddr[k]);
        end
      end
    end
    compared++;
    if (wrLog.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL read_no_write: got %0d want 0", wrLog.size());
    end
    end_frame();
  endtask

  task automatic test_wrap();
    logic [7:0] rx;
    start_frame();
    send_bits(8'h7F, 8, rx);
    send_bits(8'h11, 8, rx);
    send_bits(8'h22, 8, rx);
    compared++;
    if (wrLog.size() !== 2) begin
      mismatched++;
      $display("[TB] FAIL wrap_count: got %0d want 2", wrLog.size());
    end else begin
      compared++;
      if (wrLog[0] !== {7'h7F, 8'h11}) begin
        mismatched++;
        $display("[TB] FAIL wrap_first: got %h want %h", wrLog[0], {7'h7F, 8'h11});
      end
      compared++;
      if (wrLog[1] !== {7'h00, 8'h22}) begin
        mismatched++;
        $display("[TB] FAIL wrap_second: got %h want %h", wrLog[1], {7'h00, 8'h22});
      end
    end
    end_frame();
  endtask

  task automatic test_abort();
    logic [7:0] rx;
    start_frame();
    send_bits(8'h20, 8, rx);
    send_bits(8'hFF, 5, rx);
    compared++;
    if (wrLog.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL abort_no_write: got %0d want 0", wrLog.size());
    end
    end_frame();
    start_frame();
    send_bits(8'h21, 8, rx);
    send_bits(8'h55, 8, rx);
    compared++;
    if (wrLog.size() !== 1) begin
      mismatched++;
      $display("[TB] FAIL abort_next_count: got %0d want 1", wrLog.size());
    end else begin
      compared++;
      if (wrLog[0] !== {7'h21, 8'h55}) begin
        mismatched++;
        $display("[TB] FAIL abort_next_write: got %h want %h", wrLog[0], {7'h21, 8'h55});
      end
    end
    end_frame();
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] rx;
    start_frame();
    send_bits(8'h90, 8, rx);
    send_bits(8'h00, 8, rx);
    send_bits(8'h00, 8, rx);
    send_bits(8'h00, 1, rx);
    compared++;
    if ({rdTgl, rdAddr, spiMiso, spiMisoOe} !== {1'b1, 7'h12, 1'b1, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL midread_state: got %h want %h",
               {rdTgl, rdAddr, spiMiso, spiMisoOe}, {1'b1, 7'h12, 1'b1, 1'b1});
    end
    #2;
    rstN = 1'b0;
    #1;
    compared++;
    if ({spiMiso, spiMisoOe, wrAddr, wrData, wrTgl, rdAddr, rdTgl} !== 25'h0) begin
      mismatched++;
      $display("[TB] FAIL midread_async_reset: got %h want 0",
               {spiMiso, spiMisoOe, wrAddr, wrData, wrTgl, rdAddr, rdTgl});
    end
    prevWr = 1'b0;
    prevRd = 1'b0;
  endtask

  task automatic test_cmd_only();
    logic [7:0] rx;
    start_frame();
    send_bits(8'h40, 8, rx);
    compared++;
    if ((wrLog.size() + rdLog.size()) !== 0) begin
      mismatched++;
      $display("[TB] FAIL cmdonly_write: got %0d toggles want 0", wrLog.size() + rdLog.size());
    end
    end_frame();
    start_frame();
    send_bits(8'hC0, 8, rx);
    compared++;
    if (rdLog.size() !== 1 || wrLog.size() !== 0) begin
      mismatched++;
      $display("[TB] FAIL cmdonly_read_count: got rd %0d wr %0d want rd 1 wr 0",
               rdLog.size(), wrLog.size());
    end else begin
      compared++;
      if (rdLog[0] !== 7'h40) begin
        mismatched++;
        $display("[TB] FAIL cmdonly_read_addr: got %h want 40", rdLog[0]);
      end
    end
    end_frame();
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    prevWr = 1'b0;
    prevRd = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_wrap();
    test_abort();
    test_reset_mid_read();
    test_cmd_only();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
